// File: rtl/led_frame_scheduler.sv
// led_frame_scheduler: double-buffered 8x8 LED frame controller with round-robin row writers and boundary-aligned swap
module led_frame_scheduler #(
  parameter int FRAME_PERIOD = 2048,
  parameter int CNT_W = 11
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        i_req0_valid,
  output logic        o_req0_ready,
  input  logic [2:0]  i_req0_row,
  input  logic [7:0]  i_req0_data,
  input  logic        i_req0_commit,
  input  logic        i_req1_valid,
  output logic        o_req1_ready,
  input  logic [2:0]  i_req1_row,
  input  logic [7:0]  i_req1_data,
  input  logic        i_req1_commit,
  input  logic        i_blank,
  output logic [63:0] o_led_data,
  output logic        o_frame_tick,
  output logic        o_swap_pending
);
  logic [CNT_W-1:0] frame_cnt;
  logic [63:0] back, front;
  logic last_grant, boundary, grant0, grant1, xfer, wr_commit;
  logic [2:0] wr_row;
  logic [7:0] wr_data;
  always_comb begin
    boundary = frame_cnt == CNT_W'(FRAME_PERIOD - 1);
    grant0 = aresetn && !o_swap_pending && i_req0_valid && (!i_req1_valid || last_grant);
    grant1 = aresetn && !o_swap_pending && i_req1_valid && (!i_req0_valid || !last_grant);
    xfer = grant0 || grant1;
    wr_row = grant1 ? i_req1_row : i_req0_row;
    wr_data = grant1 ? i_req1_data : i_req0_data;
    wr_commit = grant1 ? i_req1_commit : i_req0_commit;
  end
  assign o_req0_ready = grant0;
  assign o_req1_ready = grant1;
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      frame_cnt <= '0;
      back <= '0;
      front <= '0;
      o_led_data <= '0;
      o_frame_tick <= 1'b0;
      o_swap_pending <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      frame_cnt <= boundary ? '0 : frame_cnt + 1'b1;
      o_frame_tick <= boundary;
      if (xfer) begin
        back[{wr_row, 3'b000} +: 8] <= wr_data;
        last_grant <= grant1;
      end
      // a commit can only land while nothing is pending, so it never collides with the swap
      if (boundary && o_swap_pending) begin
        front <= back;
        o_swap_pending <= 1'b0;
      end else if (xfer && wr_commit)
        o_swap_pending <= 1'b1;
      o_led_data <= i_blank ? '0 : front;
    end
endmodule

// File: tb/tb_led_frame_scheduler.sv
// tb_led_frame_scheduler: directed scoreboard bench for led_frame_scheduler
module tb_led_frame_scheduler;
  localparam int FP = 64;
  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  logic i_req0_valid = 1'b0, i_req0_commit = 1'b0, i_req1_valid = 1'b0, i_req1_commit = 1'b0;
  logic [2:0] i_req0_row = '0, i_req1_row = '0;
  logic [7:0] i_req0_data = '0, i_req1_data = '0;
  logic i_blank = 1'b0;
  logic o_req0_ready, o_req1_ready, o_frame_tick, o_swap_pending;
  logic [63:0] o_led_data;
  int checks = 0, errors = 0, k = 0, k0 = 0, g = 0;
  logic [63:0] mb = '0, front_m = '0;
  logic [63:0] exp_q[$];
  int gq[$];

  led_frame_scheduler #(.FRAME_PERIOD(FP), .CNT_W(6)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .i_req0_valid(i_req0_valid), .o_req0_ready(o_req0_ready), .i_req0_row(i_req0_row),
    .i_req0_data(i_req0_data), .i_req0_commit(i_req0_commit),
    .i_req1_valid(i_req1_valid), .o_req1_ready(o_req1_ready), .i_req1_row(i_req1_row),
    .i_req1_data(i_req1_data), .i_req1_commit(i_req1_commit),
    .i_blank(i_blank), .o_led_data(o_led_data), .o_frame_tick(o_frame_tick),
    .o_swap_pending(o_swap_pending)
  );

  always #5 aclk = ~aclk;

  // rising edges since reset release: frame_cnt == k % FP after edge k
  always @(posedge aclk or negedge aresetn)
    if (!aresetn) k <= 0;
    else k <= k + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input int p, input logic [2:0] row, input logic [7:0] d, input logic c);
    logic ok = 1'b0;
    if (p == 0) begin
      i_req0_valid = 1'b1; i_req0_row = row; i_req0_data = d; i_req0_commit = c;
    end else begin
      i_req1_valid = 1'b1; i_req1_row = row; i_req1_data = d; i_req1_commit = c;
    end
    for (int i = 0; i < 4 * FP && !ok; i++) begin
      #1;
      if ((p == 0) ? o_req0_ready : o_req1_ready) ok = 1'b1;
      else @(negedge aclk);
    end
    checks++;
    assert (ok) else begin
      errors++;
      $error("FAIL send%0d_ready observed=timeout expected=ready", p);
    end
    if (ok) @(posedge aclk);
    @(negedge aclk);
    i_req0_valid = 1'b0; i_req1_valid = 1'b0; i_req0_commit = 1'b0; i_req1_commit = 1'b0;
    k0 = k;
    if (ok) begin
      mb[{row, 3'b000} +: 8] = d;
      if (c) exp_q.push_back(mb);
    end
  endtask

  task automatic expect_swap(input string tag);
    int ks = (k0 / FP + 1) * FP;
    logic [63:0] nf;
    i_req0_valid = 1'b1; i_req1_valid = 1'b1;
    i_req0_row = 3'd5; i_req1_row = 3'd5; i_req0_data = 8'hEE; i_req1_data = 8'hEE;
    while (k < ks - 1) @(negedge aclk);
    #1;
    chk({tag, "_ready0_frozen"}, o_req0_ready, 64'h0);
    chk({tag, "_ready1_frozen"}, o_req1_ready, 64'h0);
    chk({tag, "_pending_before"}, o_swap_pending, 64'h1);
    chk({tag, "_led_before"}, o_led_data, i_blank ? 64'h0 : front_m);
    @(negedge aclk);
    i_req0_valid = 1'b0; i_req1_valid = 1'b0;
    chk({tag, "_pending_after"}, o_swap_pending, 64'h0);
    chk({tag, "_led_at_swap"}, o_led_data, i_blank ? 64'h0 : front_m);
    chk({tag, "_queue"}, 64'(exp_q.size() > 0), 64'h1);
    nf = (exp_q.size() > 0) ? exp_q.pop_front() : mb;
    front_m = nf;
    @(negedge aclk);
    chk({tag, "_led_new"}, o_led_data, i_blank ? 64'h0 : front_m);
  endtask

  initial begin
    repeat (2) @(negedge aclk);
    i_req0_valid = 1'b1; i_req1_valid = 1'b1;
    #1;
    chk("rst_ready0", o_req0_ready, 64'h0);
    chk("rst_ready1", o_req1_ready, 64'h0);
    chk("rst_led", o_led_data, 64'h0);
    chk("rst_pending", o_swap_pending, 64'h0);
    chk("rst_tick", o_frame_tick, 64'h0);
    i_req0_valid = 1'b0; i_req1_valid = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;
    for (int i = 0; i < 3 * FP; i++) begin
      @(negedge aclk);
      chk("idle_led", o_led_data, 64'h0);
      chk("idle_tick", o_frame_tick, 64'(k > 0 && k % FP == 0));
    end
    // both requesters hold valid: grants alternate starting with requester 0
    repeat (3) begin gq.push_back(0); gq.push_back(1); end
    i_req0_valid = 1'b1; i_req0_row = 3'd1; i_req0_data = 8'h11;
    i_req1_valid = 1'b1; i_req1_row = 3'd6; i_req1_data = 8'h66;
    for (int i = 0; i < 6; i++) begin
      #1;
      g = gq.pop_front();
      chk("arb_ready0", o_req0_ready, 64'(g == 0));
      chk("arb_ready1", o_req1_ready, 64'(g == 1));
      if (g == 0) mb[8 +: 8] = 8'h11;
      else mb[48 +: 8] = 8'h66;
      @(negedge aclk);
    end
    i_req0_valid = 1'b0; i_req1_valid = 1'b0;
    for (int r = 0; r < 8; r++) send(0, 3'(r), 8'(1 << r), r == 7);
    chk("diag_pending", o_swap_pending, 64'h1);
    expect_swap("diag");
    chk("diag_image", o_led_data, 64'h8040201008040201);
    while (k % FP != FP - 1) @(negedge aclk);
    send(1, 3'd2, 8'h5A, 1'b1);
    chk("bnd_tick", o_frame_tick, 64'h1);
    chk("bnd_pending", o_swap_pending, 64'h1);
    expect_swap("bnd");
    @(negedge aclk);
    i_blank = 1'b1;
    @(negedge aclk);
    chk("blank_led", o_led_data, 64'h0);
    send(0, 3'd0, 8'hC3, 1'b1);
    expect_swap("blank");
    i_blank = 1'b0;
    @(negedge aclk);
    chk("unblank_led", o_led_data, front_m);
    while (k % FP != 2) @(negedge aclk);
    send(0, 3'd0, 8'hFF, 1'b0);
    for (int r = 1; r < 7; r++) send(0, 3'(r), 8'h00, 1'b0);
    send(0, 3'd7, 8'h00, 1'b1);
    chk("prerst_pending", o_swap_pending, 64'h1);
    @(negedge aclk);
    #2;
    aresetn = 1'b0;
    i_req0_valid = 1'b1;
    #1;
    chk("midrst_led", o_led_data, 64'h0);
    chk("midrst_pending", o_swap_pending, 64'h0);
    chk("midrst_tick", o_frame_tick, 64'h0);
    chk("midrst_ready0", o_req0_ready, 64'h0);
    exp_q.delete();
    mb = '0;
    front_m = '0;
    i_req0_valid = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    chk("postrst_pending", o_swap_pending, 64'h0);
    chk("postrst_led", o_led_data, 64'h0);
    send(0, 3'd3, 8'hAA, 1'b1);
    expect_swap("postrst");
    chk("postrst_image", o_led_data, 64'h00000000AA000000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
